// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the multi-cycle sequencer.
// Opcodes, FSM states, APB phases and decode helpers.
package cpu_pkg;

  localparam int WORD_W = 16;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 13;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_SUB  = 3'b010,
    OP_NAND = 3'b011,
    OP_BNE  = 3'b100,
    OP_LW   = 3'b101,
    OP_SW   = 3'b110,
    OP_J    = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_SETUP,
    S_F_ACCESS,
    S_EXEC,
    S_M_SETUP,
    S_M_ACCESS,
    S_WB,
    S_FAULT
  } seq_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SETUP,
    P_ACCESS
  } apb_phase_e;

  function automatic logic is_mem_op(
    input opcode_e op
  );
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_alu_op(
    input opcode_e op
  );
    return op inside {OP_ADD, OP_ADDI,
                      OP_SUB, OP_NAND};
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: APB bus between sequencer and memory.
// master drives address/control/wdata, slave answers.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic [WORD_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [WORD_W-1:0] pwdata;
  logic [WORD_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable,
    output pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable,
    input  pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/cpu_sequencer_apb_master_port.sv
// apb_master_port: setup/access handshake, wait count, timeout.
// start loads addr/wr/wdata; done/err report the access outcome.
module apb_master_port
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              wr,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] rdata,
  cpu_sequencer_if.master   apb
);

  localparam int unsigned CL = $clog2(WAIT_LIMIT + 1);
  localparam int unsigned CW = (CL < 4) ? 4 : CL;
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  apb_phase_e        phase;
  apb_phase_e        phase_nxt;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] paddr_q;
  logic [WORD_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              acc;
  logic              tmo;

  assign acc  = phase == P_ACCESS;
  assign tmo  = acc && !apb.pready && (cnt == LAST);
  assign done = acc && apb.pready && !apb.pslverr;
  assign err  = (acc && apb.pready && apb.pslverr) || tmo;

  assign rdata       = apb.prdata;
  assign apb.psel    = phase != P_IDLE;
  assign apb.penable = acc;
  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;

  always_comb begin
    phase_nxt = phase;
    unique case (phase)
      P_IDLE: begin
        if (start) phase_nxt = P_SETUP;
      end
      P_SETUP: phase_nxt = P_ACCESS;
      P_ACCESS: begin
        if (start)
          phase_nxt = P_SETUP;
        else if (apb.pready || tmo)
          phase_nxt = P_IDLE;
      end
      default: phase_nxt = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= P_IDLE;
      cnt      <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (start) begin
        cnt      <= '0;
        paddr_q  <= addr;
        pwdata_q <= wdata;
        pwrite_q <= wr;
      end else if (acc && !apb.pready) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: PC/IR owner, runs fetch/exec/mem/wb over APB.
// Ports: clk, reset_n, run, datapath in, apb master, ir/pc/strobes out.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 16'h0000,
  parameter int unsigned       WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [WORD_W-1:0] alu_result,
  input  logic              rs1_ne_rs2,
  input  logic [WORD_W-1:0] rs2_data,
  cpu_sequencer_if.master   apb,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] pc,
  output logic              exec_en,
  output logic              rf_we,
  output logic              wb_sel,
  output logic [WORD_W-1:0] load_data,
  output logic              fault
);

  seq_state_e        state;
  seq_state_e        nxt;
  opcode_e           op;
  logic [WORD_W-1:0] pc_nxt;
  logic              start;
  logic              st_wr;
  logic [WORD_W-1:0] st_addr;
  logic [WORD_W-1:0] st_wdata;
  logic              done;
  logic              err;
  logic [WORD_W-1:0] rdata;

  assign op = opcode_e'(ir[OP_MSB:OP_LSB]);

  apb_master_port #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_port (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .wr      (st_wr),
    .addr    (st_addr),
    .wdata   (st_wdata),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .apb     (apb)
  );

  always_comb begin
    nxt    = state;
    pc_nxt = pc;
    unique case (state)
      S_IDLE: begin
        if (run) nxt = S_F_SETUP;
      end
      S_F_SETUP: nxt = S_F_ACCESS;
      S_F_ACCESS: begin
        if (err)
          nxt = S_FAULT;
        else if (done)
          nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_mem_op(op)) begin
          nxt = S_M_SETUP;
        end else begin
          nxt = run ? S_F_SETUP : S_IDLE;
          unique case (op)
            OP_BNE: pc_nxt = rs1_ne_rs2
                           ? alu_result
                           : pc + 1'b1;
            OP_J:    pc_nxt = alu_result;
            default: pc_nxt = pc + 1'b1;
          endcase
        end
      end
      S_M_SETUP: nxt = S_M_ACCESS;
      S_M_ACCESS: begin
        if (err) begin
          nxt = S_FAULT;
        end else if (done) begin
          if (op == OP_LW) begin
            nxt = S_WB;
          end else begin
            pc_nxt = pc + 1'b1;
            nxt    = run ? S_F_SETUP : S_IDLE;
          end
        end
      end
      S_WB: begin
        pc_nxt = pc + 1'b1;
        nxt    = run ? S_F_SETUP : S_IDLE;
      end
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_FAULT;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    st_wr    = 1'b0;
    st_addr  = pc_nxt;
    st_wdata = '0;
    unique case (1'b1)
      (nxt == S_F_SETUP): start = 1'b1;
      (nxt == S_M_SETUP): begin
        start    = 1'b1;
        st_wr    = op == OP_SW;
        st_addr  = alu_result;
        st_wdata = rs2_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      load_data <= '0;
    end else begin
      state <= nxt;
      pc    <= pc_nxt;
      if (state == S_F_ACCESS && done)
        ir <= rdata;
      if (state == S_M_ACCESS && done
          && op == OP_LW)
        load_data <= rdata;
    end
  end

  assign exec_en = state == S_EXEC;
  assign rf_we   = (state == S_EXEC && is_alu_op(op))
                || (state == S_WB);
  assign wb_sel  = state == S_WB;
  assign fault   = state == S_FAULT;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed + random instructions vs
// an instruction-level model; bench acts as APB memory.
module tb_cpu_sequencer;

  localparam logic [15:0] RST_PC = 16'h0010;
  localparam int          WL     = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] alu_result;
  logic        rs1_ne_rs2;
  logic [15:0] rs2_data;
  logic [15:0] ir;
  logic [15:0] pc;
  logic        exec_en;
  logic        rf_we;
  logic        wb_sel;
  logic [15:0] load_data;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_ld;

  cpu_sequencer_if apb();

  cpu_sequencer #(
    .RESET_PC   (RST_PC),
    .WAIT_LIMIT (WL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .alu_result (alu_result),
    .rs1_ne_rs2 (rs1_ne_rs2),
    .rs2_data   (rs2_data),
    .apb        (apb),
    .ir         (ir),
    .pc         (pc),
    .exec_en    (exec_en),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .load_data  (load_data),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    run         = 1'b0;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = '0;
    alu_result  = '0;
    rs2_data    = '0;
    rs1_ne_rs2  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl",
        {apb.psel, apb.penable, apb.pwrite,
         exec_en, rf_we, wb_sel, fault}, 7'b0);
    chk("rst_paddr", apb.paddr, 16'h0);
    chk("rst_pwdata", apb.pwdata, 16'h0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", ir, 16'h0);
    chk("rst_ld", load_data, 16'h0);
    m_pc    = RST_PC;
    m_ir    = '0;
    m_ld    = '0;
    reset_n = 1'b1;
    run     = 1'b1;
    @(negedge clk);
  endtask

  task automatic resume();
    repeat (2) @(negedge clk);
    chk("idle_hold", {apb.psel, exec_en}, 2'b00);
    run = 1'b1;
    @(negedge clk);
  endtask

  // One instruction, starting at a negedge in the fetch setup cycle.
  task automatic do_instr(
    input logic [15:0] ins,
    input logic [15:0] alu,
    input logic [15:0] rs2,
    input logic [15:0] mdat,
    input logic        ne,
    input int          wf,
    input int          wm,
    input bit          ferr,
    input bit          merr,
    input bit          drop,
    input bit          abort
  );
    logic [2:0]  op;
    logic [15:0] npc;
    bit lw, sw, mem, alu_op, f_flt, m_flt;
    int ncyc, txn, wcnt, n_ex, n_we, ex_cyc, w;

    op     = ins[15:13];
    lw     = op == 3'b101;
    sw     = op == 3'b110;
    mem    = lw || sw;
    alu_op = op < 3'd4;
    f_flt  = ferr || (wf >= WL);
    m_flt  = mem && !f_flt && (merr || (wm >= WL));

    if (f_flt) begin
      ncyc = 1 + ((wf >= WL) ? WL : wf + 1);
    end else begin
      ncyc = 3 + wf;
      if (mem)
        ncyc += 1 + ((wm >= WL) ? WL : wm + 1);
      if (lw && !m_flt)
        ncyc += 1;
    end

    case (op)
      3'b100:  npc = ne ? alu : m_pc + 16'd1;
      3'b111:  npc = alu;
      default: npc = m_pc + 16'd1;
    endcase

    alu_result = alu;
    rs2_data   = rs2;
    rs1_ne_rs2 = ne;
    txn    = 0;
    wcnt   = 0;
    n_ex   = 0;
    n_we   = 0;
    ex_cyc = 0;

    for (int c = 1; c <= ncyc; c++) begin
      if (c == 1)
        chk("start", {apb.psel, apb.penable}, 2'b10);
      if (apb.psel && !apb.penable) begin
        txn++;
        wcnt = 0;
      end
      if (apb.psel) begin
        if (txn == 1) begin
          chk("f_paddr", apb.paddr, m_pc);
          chk("f_pwrite", apb.pwrite, 1'b0);
        end else begin
          chk("m_paddr", apb.paddr, alu);
          chk("m_pwrite", apb.pwrite, sw);
          if (sw) chk("m_pwdata", apb.pwdata, rs2);
        end
      end
      if (exec_en) begin
        n_ex++;
        ex_cyc = c;
        chk("ex_ir", ir, ins);
        chk("ex_pc", pc, m_pc);
      end
      if (rf_we) begin
        n_we++;
        chk("wb_sel", wb_sel, lw);
        chk("we_psel", apb.psel, 1'b0);
        if (lw) chk("wb_ld", load_data, mdat);
      end
      if (apb.psel && apb.penable) begin
        w = (txn == 1) ? wf : wm;
        if (wcnt < w) begin
          apb.pready  = 1'b0;
          apb.pslverr = 1'b0;
          apb.prdata  = 16'($urandom);
          wcnt++;
        end else begin
          apb.pready  = 1'b1;
          apb.pslverr = (txn == 1) ? ferr : merr;
          apb.prdata  = (txn == 1) ? ins : mdat;
        end
      end else begin
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = 16'($urandom);
      end
      if (drop && c == 2) run = 1'b0;
      if (abort && txn == 2 && wcnt == 3) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_psel", apb.psel, 1'b0);
        chk("rst_pen", apb.penable, 1'b0);
        return;
      end
      @(negedge clk);
    end

    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    if (f_flt || m_flt) begin
      chk("flt", fault, 1'b1);
      chk("flt_psel", apb.psel, 1'b0);
      chk("flt_pc", pc, m_pc);
      chk("flt_ir", ir, f_flt ? m_ir : ins);
      chk("flt_ld", load_data, m_ld);
      repeat (3) @(negedge clk);
      chk("flt_hold",
          {apb.psel, exec_en, rf_we, fault}, 4'b0001);
    end else begin
      chk("n_exec", n_ex, 1);
      chk("ex_cyc", ex_cyc, 3 + wf);
      chk("n_we", n_we, (alu_op || lw) ? 1 : 0);
      if (lw) m_ld = mdat;
      m_ir = ins;
      m_pc = npc;
      chk("pc", pc, m_pc);
      chk("ld", load_data, m_ld);
      chk("no_flt", fault, 1'b0);
      if (drop)
        chk("to_idle", apb.psel, 1'b0);
      else
        chk("next_fetch",
            {apb.psel, apb.penable}, 2'b10);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [12:0] rlo;
    bit          rd;

    do_reset();
    // ADD from RESET_PC
    do_instr(16'h0490, 16'h5555, 16'h0, 16'h0,
             1'b0, 0, 0, 0, 0, 0, 0);
    // BNE taken / not taken
    do_instr(16'h8123, 16'h0040, 16'h0, 16'h0,
             1'b1, 0, 0, 0, 0, 0, 0);
    do_instr(16'h8123, 16'h0077, 16'h0, 16'h0,
             1'b0, 0, 0, 0, 0, 0, 0);
    // LW with two memory wait states
    do_instr(16'hA000, 16'h0200, 16'h0, 16'hBEEF,
             1'b0, 0, 2, 0, 0, 0, 0);
    // SW
    do_instr(16'hC000, 16'h0300, 16'h1234, 16'h0,
             1'b0, 0, 0, 0, 0, 0, 0);
    // fetch one wait short of the timeout
    do_instr(16'h2001, 16'h0, 16'h0, 16'h0,
             1'b0, WL - 1, 0, 0, 0, 0, 0);
    // jump to 0xFFFF then ADD wraps PC
    do_instr(16'hE000, 16'hFFFF, 16'h0, 16'h0,
             1'b0, 0, 0, 0, 0, 0, 0);
    do_instr(16'h0490, 16'h0, 16'h0, 16'h0,
             1'b0, 1, 0, 0, 0, 0, 0);
    // run drops mid-LW
    do_instr(16'hA000, 16'h0123, 16'h0, 16'h7777,
             1'b0, 1, 1, 0, 0, 1, 0);
    resume();

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rlo = 13'($urandom);
      rd  = $urandom_range(0, 5) == 0;
      do_instr({rop, rlo}, 16'($urandom),
               16'($urandom), 16'($urandom),
               1'($urandom),
               $urandom_range(0, 3),
               $urandom_range(0, 3),
               0, 0, rd, 0);
      if (rd) resume();
    end

    // async reset during SW access
    do_instr(16'hC555, 16'h0ABC, 16'h5A5A, 16'h0,
             1'b0, 0, 6, 0, 0, 0, 1);
    do_reset();
    // fetch slave error
    do_instr(16'h0490, 16'h0, 16'h0, 16'h0,
             1'b0, 1, 0, 1, 0, 0, 0);
    do_reset();
    // fetch timeout
    do_instr(16'h0490, 16'h0, 16'h0, 16'h0,
             1'b0, WL + 5, 0, 0, 0, 0, 0);
    do_reset();
    // LW slave error
    do_instr(16'hA000, 16'h0400, 16'h0, 16'hCAFE,
             1'b0, 0, 1, 0, 1, 0, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
